ccm_sram_hs: RTL

- Parametrised single-port synchronous SRAM with a valid/ready request channel and a valid/ready response channel.
- Adds over the plain CCM macro:
  - configurable data width, depth and read latency;
  - byte write strobes;
  - a choice of write-return mode;
  - out-of-range error reporting;
  - response backpressure with an internal in-order response buffer.
- Used as core-coupled memory (instruction/data CCM) behind the RV32I LSU and fetch units.

---
 rtl/ccm_sram_hs.sv | 139 +++++++++++++
 1 files changed

// File: rtl/ccm_sram_hs.sv
// ccm_sram_hs: single-port synchronous SRAM with valid/ready request and
// response channels, byte strobes, selectable write-return data, out-of-range
// error responses and an in-order response buffer for backpressure.
module ccm_sram_hs #(
    parameter int DW     = 32,
    parameter int AW     = 16,
    parameter int DEPTH  = 65536,
    parameter int LAT    = 1,
    parameter int WR_OLD = 0
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            REQ_VALID,
    output logic            REQ_READY,
    input  logic [AW-1:0]   ADR,
    input  logic            WE,
    input  logic [DW/8-1:0] BE,
    input  logic [DW-1:0]   D,
    output logic            RSP_VALID,
    input  logic            RSP_READY,
    output logic [DW-1:0]   Q,
    output logic            ERR
);
    localparam int NB = DW / 8;
    localparam int FD = LAT + 1;                          // response buffer depth
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;  // array index width
    localparam int PW = $clog2(FD);                       // buffer pointer width
    localparam int CW = $clog2(FD + 1);                   // count width (0..FD)

    logic [DW-1:0] r_mem [DEPTH];

    logic          w_acc;
    logic          w_pop;
    logic          w_inr;
    logic [IW-1:0] w_idx;
    logic [DW-1:0] w_rd;

    assign w_acc = REQ_VALID && REQ_READY;
    assign w_inr = ({1'b0, ADR} < (AW+1)'(DEPTH));
    assign w_idx = ADR[IW-1:0];
    assign w_rd  = r_mem[w_idx];

    // Byte-masked write commits at the acceptance edge; out-of-range writes are dropped
    always_ff @(posedge CLK) begin
        for (int b = 0; b < NB; b++) begin
            if (w_acc && WE && w_inr && BE[b])
                r_mem[w_idx][b*8 +: 8] <= D[b*8 +: 8];
        end
    end

    // Stage 0 is the combinational response formed at acceptance; stages
    // 1..LAT-1 are registers. The last stage enters the buffer on the LAT-th
    // edge so the response is visible right after it.
    logic          w_pv [LAT];
    logic          w_pe [LAT];
    logic [DW-1:0] w_pq [LAT];

    assign w_pv[0] = w_acc;
    assign w_pe[0] = !w_inr;
    assign w_pq[0] = (!w_inr || (WE && (WR_OLD == 0))) ? '0 : w_rd;

    for (genvar k = 1; k < LAT; k++) begin : g_pipe
        logic          r_v;
        logic          r_e;
        logic [DW-1:0] r_q;

        // One delay stage; valid cleared on reset so in-flight items vanish
        always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) begin
                r_v <= 1'b0;
                r_e <= 1'b0;
                r_q <= '0;
            end else begin
                r_v <= w_pv[k-1];
                r_e <= w_pe[k-1];
                r_q <= w_pq[k-1];
            end
        end

        assign w_pv[k] = r_v;
        assign w_pe[k] = r_e;
        assign w_pq[k] = r_q;
    end

    // Response buffer
    logic [DW-1:0] r_fq [FD];
    logic          r_fe [FD];
    logic [PW-1:0] r_wp;
    logic [PW-1:0] r_rp;
    logic [CW-1:0] r_fcnt;
    logic [CW-1:0] r_out;
    logic          w_fwr;

    assign w_fwr = w_pv[LAT-1];

    // Buffer storage needs no reset; the count decides what is visible
    always_ff @(posedge CLK) begin
        if (w_fwr) begin
            r_fq[r_wp] <= w_pq[LAT-1];
            r_fe[r_wp] <= w_pe[LAT-1];
        end
    end

    // Buffer pointers, fill count and outstanding-request count
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_wp   <= '0;
            r_rp   <= '0;
            r_fcnt <= '0;
            r_out  <= '0;
        end else begin
            if (w_fwr)
                r_wp <= (r_wp == PW'(FD-1)) ? '0 : r_wp + PW'(1);
            if (w_pop)
                r_rp <= (r_rp == PW'(FD-1)) ? '0 : r_rp + PW'(1);
            case ({w_fwr, w_pop})
                2'b10:   r_fcnt <= r_fcnt + CW'(1);
                2'b01:   r_fcnt <= r_fcnt - CW'(1);
                default: r_fcnt <= r_fcnt;
            endcase
            case ({w_acc, w_pop})
                2'b10:   r_out <= r_out + CW'(1);
                2'b01:   r_out <= r_out - CW'(1);
                default: r_out <= r_out;
            endcase
        end
    end

    // Limiting outstanding to FD guarantees every pipeline output finds a slot
    assign REQ_READY = RST_N && (r_out < CW'(FD));
    assign RSP_VALID = (r_fcnt != '0);
    assign w_pop     = RSP_VALID && RSP_READY;
    assign Q         = RSP_VALID ? r_fq[r_rp] : '0;
    assign ERR       = RSP_VALID ? r_fe[r_rp] : 1'b0;

    a_no_ovf: assert property (@(posedge CLK) disable iff (!RST_N)
        !(w_fwr && (r_fcnt == CW'(FD)) && !w_pop));

endmodule
